ram_stream_reader: RTL and testbench

Read-side sequencer for the Fully_Connected dual-port buffer RAMs. On a start command it walks a contiguous address range on one RAM port and drives the port's read enable and address. It collects the returned words, which arrive one cycle later with a data-valid flag, and presents them as a valid/ready stream with full backpressure. It sits between a weight or activation RAM port and the MAC datapath, replacing ad-hoc address counters in the layer controller.

---
 rtl/ram_reader_pkg.sv | 13 +
 rtl/ram_reader_fifo.sv | 63 ++++++
 rtl/ram_stream_reader.sv | 145 ++++++++++++++
 tb/tb_ram_stream_reader.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_reader_pkg.sv
// Shared types and constants for the RAM stream reader.
package ram_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_e;

  localparam int RD_FIFO_DEPTH = 2;

endpackage

// File: rtl/ram_reader_fifo.sv
// Two-entry shifting FIFO; the head entry is a register so the stream outputs
// come straight from flops.
module ram_reader_fifo
  import ram_reader_pkg::*;
#(
  parameter int DWIDTH = 16
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   push_i,
  input  logic [DWIDTH-1:0]                      din_i,
  input  logic                                   pop_i,
  output logic [DWIDTH-1:0]                      dout_o,
  output logic                                   valid_o,
  output logic [$clog2(RD_FIFO_DEPTH+1)-1:0]     count_o
);

  localparam int CW = $clog2(RD_FIFO_DEPTH + 1);

  logic [DWIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic              v0_q, v0_d, v1_q, v1_d;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    v0_d   = v0_q;
    v1_d   = v1_q;
    if (pop_i && v0_q) begin
      head_d = tail_q;
      v0_d   = v1_q;
      v1_d   = 1'b0;
    end
    // A push lands in the first free slot after any pop has shifted the queue.
    if (push_i) begin
      if (!v0_d) begin
        head_d = din_i;
        v0_d   = 1'b1;
      end else begin
        tail_d = din_i;
        v1_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      v0_q   <= 1'b0;
      v1_q   <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      v0_q   <= v0_d;
      v1_q   <= v1_d;
    end
  end

  assign dout_o  = head_q;
  assign valid_o = v0_q;
  assign count_o = CW'(v0_q) + CW'(v1_q);

endmodule

// File: rtl/ram_stream_reader.sv
// Walks a contiguous RAM address range and streams the words out with backpressure.
// RAM_READER_WRAP_EN: wrap addresses modulo RAM_DEEP and never reject a command.
//   state | meaning
//   IDLE  | waiting for start
//   READ  | issuing reads while credit allows
//   DRAIN | all reads issued, waiting for the last handshake
//   DONE  | one-cycle done pulse
module ram_stream_reader
  import ram_reader_pkg::*;
#(
  parameter int RAM_DEEP = 40,
  parameter int DWIDTH   = 16,
  parameter int AWIDTH   = $clog2(RAM_DEEP)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [AWIDTH-1:0] base_addr,
  input  logic [AWIDTH:0]   length,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              ram_re,
  output logic [AWIDTH-1:0] ram_addr,
  input  logic [DWIDTH-1:0] ram_dout,
  input  logic              ram_dvalid,
  output logic [DWIDTH-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
);

  localparam int CW = $clog2(RD_FIFO_DEPTH + 1);

  rd_state_e         state_q, state_d;
  logic [AWIDTH-1:0] addr_q, addr_d, addr_inc;
  logic [AWIDTH:0]   rem_q, rem_d, len_q, len_d, beat_q, beat_d;
  logic              inflight_q, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [CW-1:0]     fifo_count;
  logic [2:0]        occ;
  logic              pop, push, issue, illegal;

`ifdef RAM_READER_WRAP_EN
  assign addr_inc = (addr_q == AWIDTH'(RAM_DEEP - 1)) ? '0 : addr_q + 1'b1;
  assign illegal  = 1'b0;
`else
  localparam logic [AWIDTH+1:0] DEEP_W = (AWIDTH+2)'(RAM_DEEP);
  assign addr_inc = addr_q + 1'b1;
  assign illegal  = ({2'b00, base_addr} >= DEEP_W) ||
                    (({2'b00, base_addr} + {1'b0, length}) > DEEP_W);
`endif

  assign pop    = m_valid & m_ready;
  assign push   = ram_dvalid && (state_q == READ || state_q == DRAIN);
  // Words already committed: FIFO contents plus the word returning this cycle.
  assign occ    = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
  assign issue  = (state_q == READ) && (occ < 3'd2);
  assign m_last = m_valid && (beat_q == len_q - 1'b1);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    len_d   = len_q;
    beat_d  = beat_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (length == '0) begin
            state_d = DONE;
          end else if (illegal) begin
            err_d = 1'b1;
          end else begin
            addr_d  = base_addr;
            rem_d   = length;
            len_d   = length;
            beat_d  = '0;
            state_d = READ;
          end
        end
      end
      READ: begin
        if (issue) begin
          addr_d = addr_inc;
          rem_d  = rem_q - 1'b1;
          if (rem_q == 1) state_d = DRAIN;
        end
        if (pop) beat_d = beat_q + 1'b1;
      end
      DRAIN: begin
        if (pop) begin
          beat_d = beat_q + 1'b1;
          if (m_last) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == READ) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      inflight_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      inflight_q <= issue;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  ram_reader_fifo #(.DWIDTH(DWIDTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .din_i   (ram_dout),
    .pop_i   (pop),
    .dout_o  (m_data),
    .valid_o (m_valid),
    .count_o (fifo_count)
  );

  assign ram_re   = issue;
  assign ram_addr = addr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader with a one-cycle-latency RAM model (mem[i] = i + 100).
module tb_ram_stream_reader;

  localparam int RAM_DEEP = 40;
  localparam int DWIDTH   = 16;
  localparam int AWIDTH   = $clog2(RAM_DEEP);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [AWIDTH-1:0] base_addr = '0;
  logic [AWIDTH:0]   length = '0;
  logic              busy, done, err, ram_re;
  logic [AWIDTH-1:0] ram_addr;
  logic [DWIDTH-1:0] ram_dout = '0;
  logic              ram_dvalid = 1'b0;
  logic [DWIDTH-1:0] m_data;
  logic              m_valid, m_last;
  logic              m_ready = 1'b1;

  always #5 clk = ~clk;

  ram_stream_reader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .ram_re     (ram_re),
    .ram_addr   (ram_addr),
    .ram_dout   (ram_dout),
    .ram_dvalid (ram_dvalid),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last)
  );

  always @(posedge clk) begin
    ram_dvalid <= ram_re;
    ram_dout   <= (ram_re && ram_addr < RAM_DEEP) ? DWIDTH'(ram_addr + 100) : '0;
  end

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int c0, issued, popped, max_out, done_cnt, done_cyc, err_cnt, err_cyc, busy_cnt;
  bit done_busy, hold_pend;
  logic [DWIDTH-1:0] hold_data;
  int bdata[$];
  int blast[$];
  int bcyc[$];
  int addrs[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr();
    issued = 0; popped = 0; max_out = 0;
    done_cnt = 0; done_cyc = -1; err_cnt = 0; err_cyc = -1; busy_cnt = 0;
    done_busy = 1'b0; hold_pend = 1'b0;
    bdata.delete(); blast.delete(); bcyc.delete(); addrs.delete();
  endtask

  // Called at posedge+1 with inputs set; samples at the negedge, returns at next posedge+1.
  task automatic tick();
    @(negedge clk);
    if (rst_n) begin
      if (hold_pend) chk("hold", {m_valid, m_data}, {1'b1, hold_data});
      hold_pend = m_valid && !m_ready;
      hold_data = m_data;
      if (ram_re) begin issued++; addrs.push_back(int'(ram_addr)); end
      if (m_valid && m_ready) begin
        popped++;
        bdata.push_back(int'(m_data));
        blast.push_back(int'(m_last));
        bcyc.push_back(cyc);
      end
      if (issued - popped > max_out) max_out = issued - popped;
      if (done) begin done_cnt++; done_cyc = cyc; done_busy = busy; end
      if (err) begin err_cnt++; err_cyc = cyc; end
      if (busy) busy_cnt++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // mode 0: ready held 1; 1: ready 1,0,0,1 repeating; 2: ready held 0.
  task automatic run_cmd(input int base, input int len, input int mode, input int cycles,
                         input int resend_at);
    clr();
    base_addr = AWIDTH'(base);
    length    = (AWIDTH+1)'(len);
    start     = 1'b1;
    tick();
    start = 1'b0;
    c0    = cyc;
    for (int k = 0; k < cycles; k++) begin
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (k % 4 == 0) || (k % 4 == 3);
        default: m_ready = 1'b0;
      endcase
      if (k == resend_at) begin
        start = 1'b1; base_addr = AWIDTH'(20); length = (AWIDTH+1)'(3);
      end
      tick();
      start = 1'b0;
    end
    m_ready = 1'b1;
  endtask

  task automatic check_stream(input string tag, input int first, input int n, input bit timed);
    chk({tag, "_beats"}, bdata.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < bdata.size()) begin
        chk({tag, "_data"}, bdata[i], first + i);
        chk({tag, "_last"}, blast[i], (i == n - 1) ? 1 : 0);
        if (timed) chk({tag, "_beat_cyc"}, bcyc[i], c0 + 2 + i);
      end
    end
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_outstanding_le2"}, (max_out <= 2) ? 1 : 0, 1);
    chk({tag, "_issued"}, issued, n);
  endtask

  initial begin
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_ram_re", ram_re, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_data", m_data, 0);
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // base 5, length 4, ready held high
    run_cmd(5, 4, 0, 10, -1);
    check_stream("basic", 105, 4, 1'b1);
    chk("basic_first_re_addr", (addrs.size() > 0) ? addrs[0] : -1, 5);
    chk("basic_done_cyc", done_cyc, c0 + 6);
    chk("basic_done_busy", done_busy, 0);
    chk("basic_busy_cycles", busy_cnt, 6);

    // same command with ready toggling 1,0,0,1
    run_cmd(5, 4, 1, 40, -1);
    check_stream("bp", 105, 4, 1'b0);

    // zero length
    run_cmd(5, 0, 0, 6, -1);
    chk("len0_issued", issued, 0);
    chk("len0_beats", popped, 0);
    chk("len0_done_cnt", done_cnt, 1);
    chk("len0_done_cyc", done_cyc, c0);
    chk("len0_busy", busy_cnt, 0);

    // start while busy is ignored
    run_cmd(5, 4, 0, 10, 1);
    check_stream("rebusy", 105, 4, 1'b1);
    chk("rebusy_err", err_cnt, 0);

`ifdef RAM_READER_WRAP_EN
    run_cmd(38, 4, 0, 10, -1);
    chk("wrap_err", err_cnt, 0);
    chk("wrap_issued", issued, 4);
    begin
      int exp_a[4] = '{38, 39, 0, 1};
      int exp_d[4] = '{138, 139, 100, 101};
      for (int i = 0; i < 4; i++) begin
        if (i < addrs.size()) chk("wrap_addr", addrs[i], exp_a[i]);
        if (i < bdata.size()) chk("wrap_data", bdata[i], exp_d[i]);
      end
    end
    chk("wrap_done_cnt", done_cnt, 1);
`else
    run_cmd(38, 4, 0, 6, -1);
    chk("range_err_cnt", err_cnt, 1);
    chk("range_err_cyc", err_cyc, c0);
    chk("range_issued", issued, 0);
    chk("range_busy", busy_cnt, 0);
    chk("range_done", done_cnt, 0);

    run_cmd(40, 1, 0, 6, -1);
    chk("base_oob_err", err_cnt, 1);
    chk("base_oob_issued", issued, 0);

    run_cmd(36, 4, 0, 10, -1);
    chk("edge_err", err_cnt, 0);
    check_stream("edge", 136, 4, 1'b1);
`endif

    // reset mid-command with the FIFO full
    run_cmd(10, 8, 2, 4, -1);
    #2;
    chk("pre_rst_valid", m_valid, 1);
    chk("pre_rst_issued", issued, 2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ram_re", ram_re, 0);
    chk("mid_rst_ram_addr", ram_addr, 0);
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_m_data", m_data, 0);
    chk("mid_rst_m_last", m_last, 0);
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    run_cmd(0, 2, 0, 8, -1);
    check_stream("post_rst", 100, 2, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
